// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;

    localparam int GROUP = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2,
        OP_SBC = 2'd3
    } op_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead slice: sum, group carry-out, carry into
// the top bit (for overflow detection) and a slice-is-zero indication.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             cin_i,
    output logic [GROUP-1:0] sum_o,
    output logic             cout_o,
    output logic             c3_o,
    output logic             zero_o
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a_i & b_i;
    assign p = a_i | b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = a_i ^ b_i ^ c[GROUP-1:0];
    assign cout_o = c[GROUP];
    assign c3_o   = c[GROUP-1];
    assign zero_o = (sum_o == '0);

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined add/subtract: one 4-bit lookahead group per stage, valid/ready on
// both sides with bubble collapsing and full-throughput streaming.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int NUM_GROUPS = WIDTH / GROUP;

    if (GROUP != 4) begin : g_bad_group
        $error("cla_addsub_pipe: GROUP must be 4");
    end
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_width
        $error("cla_addsub_pipe: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [WIDTH-1:0]      b_eff;
    logic                  c0;
    logic [NUM_GROUPS-1:0] stage_valid;
    logic [NUM_GROUPS-1:0] adv;

    always_comb begin
        b_eff = in_b;
        c0    = 1'b0;
        case (op_e'(in_op))
            OP_ADD:  begin b_eff = in_b;  c0 = 1'b0;   end
            OP_ADC:  begin b_eff = in_b;  c0 = in_cin; end
            OP_SUB:  begin b_eff = ~in_b; c0 = 1'b1;   end
            OP_SBC:  begin b_eff = ~in_b; c0 = in_cin; end
            default: begin b_eff = in_b;  c0 = 1'b0;   end
        endcase
    end

    // Stage k may load when any stage from k to the output has room, or the
    // consumer takes the output beat this cycle.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        for (int k = NUM_GROUPS - 1; k >= 0; k--) begin
            all_full = all_full & stage_valid[k];
            adv[k]   = out_ready | ~all_full;
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
        localparam int LO  = GROUP * k;
        localparam int REM = WIDTH - GROUP * (k + 1);

        logic [WIDTH-LO-1:0]   a_src;
        logic [WIDTH-LO-1:0]   b_src;
        logic                  valid_in;
        logic                  zero_in;
        logic                  grp_cin;
        logic [GROUP-1:0]      grp_sum;
        logic                  grp_cout;
        logic                  grp_c3;
        logic                  grp_zero;
        logic [LO+GROUP-1:0]   y_d;
        logic [LO+GROUP-1:0]   y_q;
        logic                  valid_q;
        logic                  c_q;
        logic                  z_q;
        logic                  load;

        if (k == 0) begin : g_first
            assign a_src    = in_a;
            assign b_src    = b_eff;
            assign valid_in = in_valid;
            assign zero_in  = 1'b1;
            assign grp_cin  = c0;
            assign y_d      = grp_sum;
        end else begin : g_next
            assign a_src    = g_stage[k-1].g_rem.a_rem_q;
            assign b_src    = g_stage[k-1].g_rem.b_rem_q;
            assign valid_in = g_stage[k-1].valid_q;
            assign zero_in  = g_stage[k-1].z_q;
            assign grp_cin  = g_stage[k-1].c_q;
            assign y_d      = {grp_sum, g_stage[k-1].y_q};
        end

        cla_group4 u_group (
            .a_i    (a_src[GROUP-1:0]),
            .b_i    (b_src[GROUP-1:0]),
            .cin_i  (grp_cin),
            .sum_o  (grp_sum),
            .cout_o (grp_cout),
            .c3_o   (grp_c3),
            .zero_o (grp_zero)
        );

        // Data only loads with a real beat, so out_y holds the last result
        // once the stream drains.
        assign load           = adv[k] & valid_in;
        assign stage_valid[k] = valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                y_q     <= '0;
                c_q     <= 1'b0;
                z_q     <= 1'b0;
            end else begin
                if (adv[k]) valid_q <= valid_in;
                if (load) begin
                    y_q <= y_d;
                    c_q <= grp_cout;
                    z_q <= zero_in & grp_zero;
                end
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;
            logic           unused_c3;

            assign unused_c3 = grp_c3;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (load) begin
                    a_rem_q <= a_src[WIDTH-LO-1:GROUP];
                    b_rem_q <= b_src[WIDTH-LO-1:GROUP];
                end
            end
        end else begin : g_last
            logic   v_q;
            logic   n_q;
            flags_t flags;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    n_q <= 1'b0;
                end else if (load) begin
                    v_q <= grp_c3 ^ grp_cout;
                    n_q <= grp_sum[GROUP-1];
                end
            end

            assign flags     = '{c: c_q, v: v_q, z: z_q, n: n_q};
            assign out_valid = valid_q;
            assign out_y     = y_q;
            assign out_c     = flags.c;
            assign out_v     = flags.v;
            assign out_z     = flags.z;
            assign out_n     = flags.n;
        end
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit. WIDTH bits are split into 4-bit lookahead groups, with one pipeline stage per group.
- Valid/ready handshake on input and output. Full-throughput streaming, with backpressure.
- Produces result plus carry, signed-overflow, zero and negative flags.
- Feeds the ALU datapath and replaces single-cycle 4-bit adders wherever width or timing requires it.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise).
- GROUP, 4, lookahead group width; fixed at 4 (localparam-checked).
- NUM_GROUPS, WIDTH/GROUP, derived; equals pipeline depth and latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_op  in  2  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in, used only by ADC/SBC
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_c  out  1  carry out of MSB (for SUB/SBC, 1 = no borrow)
- out_v  out  1  signed overflow
- out_z  out  1  result == 0
- out_n  out  1  out_y[WIDTH-1]

Behaviour:
- Reset is asynchronous and active-high. All stage valid bits and all data/flag registers clear to 0 immediately, so out_valid=0 and out_y/flags=0. in_ready=1 the cycle after reset deasserts. No pre-reset beat ever emerges.
- Operand conditioning at acceptance (in_valid && in_ready):
  - ADD: b_eff=in_b, c0=0.
  - ADC: b_eff=in_b, c0=in_cin.
  - SUB: b_eff=~in_b, c0=1.
  - SBC: b_eff=~in_b, c0=in_cin.
- Stage k (k=0..NUM_GROUPS-1):
  - Computes group k bits [4k+3:4k] with 4-bit CLA logic: g=a&b, p=a|b, carries c(i+1)=g|p&c(i), sum=a^b^c.
  - Uses the carry registered from stage k-1 (c0 for k=0).
  - Registers the sum slice, group carry-out, and running zero (zero_in & (slice==0)).
  - Unprocessed operand bits travel along with the beat.
- Last stage additionally registers:
  - v = carry into MSB XOR carry out of MSB.
  - n = sum MSB.
- Latency: a beat accepted at edge t presents out_valid=1 at edge t+NUM_GROUPS, given no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - stage k advances iff valid_k==0 or stage k+1 advances; the last stage advances iff !out_valid || out_ready.
  - in_ready = stage 0 advance condition (combinational from downstream ready; no combinational path in_valid -> in_ready).
  - Bubbles collapse, so a stalled pipeline still fills empty stages.
  - Held stages keep data stable. out_y and flags do not change while out_valid && !out_ready.
  - Ordering is strictly preserved, and nothing is dropped or duplicated.
- Capacity: with out_ready=0 the unit holds NUM_GROUPS beats, and in_ready then reads 0.
- Simultaneous accept at input and output in the same cycle while full is permitted and sustains throughput.
- Carry and wrap-around: the result is modulo 2^WIDTH, and out_c reports the discarded bit.
- in_cin is ignored for ADD/SUB.

Decomposition:
- Shared package cla_pkg holds:
  - the op_e enum (OP_ADD=0, OP_ADC=1, OP_SUB=2, OP_SBC=3);
  - the GROUP=4 constant;
  - the flags_t struct {c, v, z, n}.
- One sub-module, cla_group4: a combinational 4-bit CLA producing sum[3:0], group carry-out, carry into bit 3, and slice-zero. It is instantiated once per stage.
- Stage registers and handshake live in cla_addsub_pipe (generate loop).

Test Plan (WIDTH=16, latency 4):
- ADD 0x7FFF+0x0001, out_ready=1 -> out_valid 4 cycles after accept, y=0x8000, c=0, v=1, z=0, n=1.
- ADD 0xFFFF+0x0001 -> y=0x0000, c=1, v=0, z=1, n=0. Also ADC 0x00FF+0x0000 cin=1 -> y=0x0100, c=0, z=0.
- SUB 0x1234-0x1234 -> y=0x0000, c=1, z=1, v=0. SBC 0x0000-0x0001 cin=0 -> y=0xFFFE, c=0, n=1, v=0. SUB 0x8000-0x0001 -> y=0x7FFF, v=1, c=1.
- Stream 10 beats A=i, B=1, ADD, with out_ready=0 from cycle 2 to 9:
  - in_ready drops after 4 beats held;
  - outputs stay stable while stalled;
  - after release, results 1..10 arrive in order with none lost or duplicated.
- Back-to-back 20 random beats with out_ready=1 -> one result per cycle, each matching a reference model (result and all four flags).
- Assert rst for 1 cycle while 3 beats are in flight -> out_valid=0 and flags=0 immediately (async). No in-flight result ever appears, and the next accepted beat (ADD 2+3) emerges as y=5 after 4 cycles.
